// File: rtl/readhead_gen.sv
// Code-wheel readhead emulator: slot pulse train with a missing-slot gap at mechanical zero.
// Optional slot-period jitter is compiled in with `define READHEAD_JITTER_EN.
module readhead_gen #(
  parameter int TEETH = 200,
  parameter int GAP   = 2,
  parameter int PW    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [PW-1:0]            slot_period,
  output logic                     readhead_sig,
  output logic [$clog2(TEETH)-1:0] slot_idx,
  output logic                     rev_pulse,
  output logic                     running
);

  localparam int SW = $clog2(TEETH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(TEETH - 1);
  localparam logic [SW-1:0] GAP_START = SW'(TEETH - GAP);
  localparam logic [PW-1:0] MIN_P     = PW'(4);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   phase, phase_n;
  logic [PW-1:0]   per, per_n;
  logic [SW-1:0]   slot_n, slot_inc;
  logic            sig_n, rev_n, run_n;
  logic [PW-1:0]   p_clamp, p_eff;
  logic            at_boundary;

  assign p_clamp     = (slot_period < MIN_P) ? MIN_P : slot_period;
  assign at_boundary = (phase == per - PW'(1));
  assign slot_inc    = (slot_idx == LAST_SLOT) ? '0 : slot_idx + SW'(1);

`ifdef READHEAD_JITTER_EN
  logic [7:0]  lfsr;
  logic [PW:0] jit_adj;

  // Effective period = P + lfsr[2:0] - 4, clamped to >= 4 and saturated at the counter width.
  assign jit_adj = {1'b0, p_clamp} + {{(PW-2){1'b0}}, lfsr[2:0]} - (PW+1)'(4);

  always_comb begin
    if (jit_adj[PW])                     p_eff = '1;
    else if (jit_adj[PW-1:0] < MIN_P)    p_eff = MIN_P;
    else                                 p_eff = jit_adj[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)                           lfsr <= 8'hA5;
    else if (state == RUN && at_boundary) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign p_eff = p_clamp;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_n = state;
    phase_n = phase;
    per_n   = per;
    slot_n  = slot_idx;
    sig_n   = 1'b0;
    rev_n   = 1'b0;
    run_n   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = RUN;
          per_n   = p_eff;
          phase_n = '0;
          run_n   = 1'b1;
          sig_n   = (slot_idx < GAP_START);   // phase 0 is always in the high half
        end
      end
      RUN: begin
        run_n = 1'b1;
        if (at_boundary) begin
          phase_n = '0;
          per_n   = p_eff;
          slot_n  = slot_inc;
          rev_n   = (slot_idx == LAST_SLOT);
          if (!enable) begin
            state_n = IDLE;
            run_n   = 1'b0;
          end else begin
            sig_n = (slot_inc < GAP_START);
          end
        end else begin
          phase_n = phase + PW'(1);
          sig_n   = (phase_n < (per >> 1)) && (slot_idx < GAP_START);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      per          <= MIN_P;
      slot_idx     <= '0;
      readhead_sig <= 1'b0;
      rev_pulse    <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      per          <= per_n;
      slot_idx     <= slot_n;
      readhead_sig <= sig_n;
      rev_pulse    <= rev_n;
      running      <= run_n;
    end
  end

endmodule

// File: tb/tb_readhead_gen.sv
// Self-checking bench for readhead_gen (TEETH=8, GAP=1, jitter off): vector table,
// hand-written corner sequences, and randomized stimulus against a queue-based waveform model.
module tb_readhead_gen;

  localparam int TEETH = 8;
  localparam int GAP   = 1;
  localparam int PW    = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] slot_period;
  logic          readhead_sig;
  logic [2:0]    slot_idx;
  logic          rev_pulse;
  logic          running;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  readhead_gen #(.TEETH(TEETH), .GAP(GAP), .PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .slot_period  (slot_period),
    .readhead_sig (readhead_sig),
    .slot_idx     (slot_idx),
    .rev_pulse    (rev_pulse),
    .running      (running)
  );

  typedef struct {int sp; int hi; int lo;} clamp_vec_t;
  typedef struct packed {logic sig; logic [2:0] idx; logic rev; logic run;} obs_t;

  // Waveform model: a slot start pushes the whole slot's expected cycles into a queue.
  obs_t q[$];
  obs_t cur;
  int   m_slot;
  bit   m_run;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst    = 1'b1;
    enable = 1'b0;
    tick;
    rst    = 1'b0;
  endtask

  function automatic void fill_slot(input int s, input int p, input bit rv);
    for (int c = 0; c < p; c++) begin
      obs_t o;
      o.sig = (s < TEETH - GAP) && (c < p / 2);
      o.idx = s[2:0];
      o.rev = rv && (c == 0);
      o.run = 1'b1;
      q.push_back(o);
    end
  endfunction

  function automatic void model_step(input bit r, input bit en, input int sp);
    int  p;
    bit  wrap;
    p = (sp < 4) ? 4 : sp;
    if (r) begin
      q.delete();
      m_slot = 0;
      m_run  = 0;
      cur    = '0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1;
        fill_slot(m_slot, p, 1'b0);
        cur = q.pop_front();
      end else begin
        cur     = '0;
        cur.idx = m_slot[2:0];
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      wrap   = (m_slot == TEETH - 1);
      m_slot = (m_slot + 1) % TEETH;
      if (en) begin
        fill_slot(m_slot, p, wrap);
        cur = q.pop_front();
      end else begin
        m_run   = 0;
        cur     = '0;
        cur.idx = m_slot[2:0];
        cur.rev = wrap;
      end
    end
  endfunction

  initial begin
    clamp_vec_t vecs[6];
    int hi, lo, revs, t1, t2, s7len, s7hi, len2, len3, act;
    obs_t dut_obs;
    bit   r_en, r_rst;
    int   r_sp;

    vecs[0] = '{sp: 1,  hi: 2, lo: 2};
    vecs[1] = '{sp: 0,  hi: 2, lo: 2};
    vecs[2] = '{sp: 4,  hi: 2, lo: 2};
    vecs[3] = '{sp: 5,  hi: 2, lo: 3};
    vecs[4] = '{sp: 9,  hi: 4, lo: 5};
    vecs[5] = '{sp: 10, hi: 5, lo: 5};

    slot_period = 24'd10;
    do_reset;
    check("reset_sig",  readhead_sig, 0);
    check("reset_idx",  slot_idx, 0);
    check("reset_rev",  rev_pulse, 0);
    check("reset_run",  running, 0);

    // First-slot high/low split for a range of programmed periods, including clamped ones.
    foreach (vecs[i]) begin
      do_reset;
      slot_period = PW'(vecs[i].sp);
      enable      = 1'b1;
      tick;
      check("run_after_enable", running, 1);
      hi = 0;
      lo = 0;
      for (int n = 0; n < 100 && slot_idx == 0; n++) begin
        if (readhead_sig) hi++;
        else              lo++;
        tick;
      end
      check($sformatf("slot0_high_sp%0d", vecs[i].sp), hi, vecs[i].hi);
      check($sformatf("slot0_low_sp%0d",  vecs[i].sp), lo, vecs[i].lo);
    end

    // Gap slot and rev pulse spacing.
    do_reset;
    slot_period = 24'd10;
    enable      = 1'b1;
    tick;
    revs = 0; t1 = -1; t2 = -1; s7len = 0; s7hi = 0;
    for (int c = 0; c < 170; c++) begin
      if (rev_pulse) begin
        revs++;
        if (t1 < 0)      t1 = c;
        else if (t2 < 0) t2 = c;
      end
      if (c < 80 && slot_idx == 3'd7) begin
        s7len++;
        if (readhead_sig) s7hi++;
      end
      tick;
    end
    check("rev_count", revs, 2);
    check("rev_first", t1, 80);
    check("rev_spacing", t2 - t1, 80);
    check("gap_slot_len", s7len, 10);
    check("gap_slot_high", s7hi, 0);

    // Period change mid-slot takes effect at the next slot.
    do_reset;
    slot_period = 24'd10;
    enable      = 1'b1;
    tick;
    len2 = 0; len3 = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 23) slot_period = 24'd20;
      if (slot_idx == 3'd2) len2++;
      if (slot_idx == 3'd3) len3++;
      tick;
    end
    check("slot2_len", len2, 10);
    check("slot3_len", len3, 20);

    // Enable drop mid-slot completes the slot, then idles holding the next index.
    do_reset;
    slot_period = 24'd10;
    enable      = 1'b1;
    tick;
    for (int c = 0; c < 30; c++) begin
      if (c == 23) enable = 1'b0;
      tick;
    end
    check("stop_run", running, 0);
    check("stop_sig", readhead_sig, 0);
    check("stop_idx", slot_idx, 3);
    for (int c = 0; c < 5; c++) tick;
    check("idle_hold_idx", slot_idx, 3);
    check("idle_hold_run", running, 0);
    enable = 1'b1;
    tick;
    check("resume_run", running, 1);
    check("resume_idx", slot_idx, 3);
    check("resume_sig", readhead_sig, 1);
    check("resume_rev", rev_pulse, 0);

    // Stop coinciding with the wrap still produces one rev pulse.
    for (int d = 0; d < 50; d++) begin
      if (d == 45) enable = 1'b0;
      tick;
    end
    check("stopwrap_rev", rev_pulse, 1);
    check("stopwrap_idx", slot_idx, 0);
    check("stopwrap_run", running, 0);
    tick;
    check("stopwrap_rev_width", rev_pulse, 0);

    // Reset during the high phase of slot 4.
    do_reset;
    slot_period = 24'd10;
    enable      = 1'b1;
    tick;
    for (int c = 0; c < 41; c++) tick;
    check("pre_reset_sig", readhead_sig, 1);
    check("pre_reset_idx", slot_idx, 4);
    rst = 1'b1;
    tick;
    check("midreset_outputs", {28'd0, readhead_sig, rev_pulse, running, |slot_idx}, 0);
    rst    = 1'b0;
    enable = 1'b0;
    act    = 0;
    for (int c = 0; c < 20; c++) begin
      if (readhead_sig || rev_pulse || running) act++;
      tick;
    end
    check("post_reset_quiet", act, 0);

    // Randomized run against the waveform model.
    for (int i = 0; i < 3000; i++) begin
      r_rst = (i == 0) || ($urandom_range(0, 299) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      r_sp  = $urandom_range(0, 14);
      rst         = r_rst;
      enable      = r_en;
      slot_period = PW'(r_sp);
      model_step(r_rst, r_en, r_sp);
      tick;
      dut_obs = {readhead_sig, slot_idx, rev_pulse, running};
      check($sformatf("random_cycle%0d", i), {26'd0, dut_obs}, {26'd0, cur});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
